// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: widths, iteration
// count and state encoding.
package mult_div_unit_pkg;

  localparam int         MDU_WIDTH = 32;
  localparam logic [5:0] ITER      = 6'd32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [MDU_WIDTH-1:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_diff;

  assign w_diff = i_rem - {1'b0, i_divisor};
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : i_rem[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed 32-bit multiply/divide for the execute stage: one bit per
// cycle on operand magnitudes, sign fix-up and exception flagging at completion.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             resultRDY,
  output logic             busy
);

  logic [1:0]         r_state;
  logic [5:0]         r_count;
  logic               r_busy;
  logic               r_rdy;
  logic               r_exc;
  logic [WIDTH-1:0]   r_result;
  logic               r_is_div;
  logic               r_neg;
  logic               r_b_zero;
  logic               r_div_ovf;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb_mag;

  logic               w_start;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_final;
  logic               w_final_exc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_count == ITER);
  assign w_a_mag = operandA[WIDTH-1] ? -operandA : operandA;
  assign w_b_mag = operandB[WIDTH-1] ? -operandB : operandB;

  // Accumulator layout: upper half is the running sum / partial remainder,
  // lower half holds the multiplier / dividend bits being consumed.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb_mag} : '0);
  assign w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_acc = {w_rem_next, r_acc[WIDTH-2:0], w_qbit};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (w_shift),
    .i_divisor (r_opb_mag),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_comb begin
    w_prod      = r_neg ? -r_acc : r_acc;
    w_quo       = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_final     = w_prod[WIDTH-1:0];
    w_final_exc = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    if (r_is_div) begin
      if (r_b_zero) begin
        w_final     = '0;
        w_final_exc = 1'b1;
      end else if (r_div_ovf) begin
        w_final     = INT_MIN;
        w_final_exc = 1'b1;
      end else begin
        w_final     = w_quo;
        w_final_exc = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_rdy     <= 1'b0;
      r_exc     <= 1'b0;
      r_result  <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_b_zero  <= 1'b0;
      r_div_ovf <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_state   <= ctrl_MULT ? S_MUL : S_DIV;
        r_count   <= '0;
        r_busy    <= 1'b1;
        r_is_div  <= ~ctrl_MULT;
        r_neg     <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
        r_b_zero  <= (operandB == '0);
        r_div_ovf <= (operandA == INT_MIN) && (operandB == '1);
      end else begin
        case (r_state)
          S_MUL, S_DIV: begin
            if (w_last) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_rdy    <= 1'b1;
              r_result <= w_final;
              r_exc    <= w_final_exc;
            end else begin
              r_count <= r_count + 6'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath registers carry no reset; they are reloaded by every start.
  always_ff @(posedge clock) begin
    if (w_start) begin
      r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
      r_opb_mag <= w_b_mag;
    end else if (r_busy && !w_last) begin
      r_acc <= r_is_div ? w_div_acc : w_mul_acc;
    end
  end

  assign result    = r_result;
  assign exception = r_exc;
  assign resultRDY = r_rdy;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: fixed 33-cycle latency, signed results,
// exception cases, abort-by-restart and asynchronous reset mid-operation.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] result;
  logic        exception;
  logic        resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mult_div_unit dut (
    .clock     (clock),
    .reset     (reset),
    .operandA  (operandA),
    .operandB  (operandB),
    .ctrl_MULT (ctrl_MULT),
    .ctrl_DIV  (ctrl_DIV),
    .result    (result),
    .exception (exception),
    .resultRDY (resultRDY),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a start on the falling edge; returns 1ns after the sampling edge E0.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV  = d;
    operandA  = a;
    operandB  = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    operandA  = $urandom;
    operandB  = $urandom;
  endtask

  // Called right after start_op: walks E1..E34 and checks the completion window.
  task automatic finish_op(input string tag, input logic [31:0] exp_res, input logic exp_exc);
    int pulses = 0;
    int idle   = 0;
    repeat (32) begin
      @(posedge clock);
      #1;
      if (resultRDY) pulses++;
      if (!busy) idle++;
    end
    chk({tag, "_early_rdy"}, 32'(pulses), 32'd0);
    chk({tag, "_busy_drop"}, 32'(idle), 32'd0);
    @(posedge clock);
    #1;
    chk({tag, "_rdy"}, {31'd0, resultRDY}, 32'd1);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_exc"}, {31'd0, exception}, {31'd0, exp_exc});
    @(posedge clock);
    #1;
    chk({tag, "_rdy_pulse"}, {31'd0, resultRDY}, 32'd0);
    chk({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    operandA  = '0;
    operandB  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_rdy", {31'd0, resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    chk("mul7_busy", {31'd0, busy}, 32'd1);
    finish_op("mul7", 32'hFFFF_FFD6, 1'b0);

    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    chk("start_keeps_result", result, 32'hFFFF_FFD6);
    finish_op("mul_ovf", 32'h0000_0000, 1'b1);

    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("start_keeps_exc", {31'd0, exception}, 32'd1);
    finish_op("mul_m1m1", 32'h0000_0001, 1'b0);

    start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    finish_op("mul_intmin", 32'h8000_0000, 1'b0);

    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 32'hFFFF_FFFD, 1'b0);

    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'h8000_0000, 1'b1);

    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    finish_op("div_zero", 32'h0000_0000, 1'b1);

    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(posedge clock);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    finish_op("abort", 32'd14, 1'b0);

    start_op(1'b1, 1'b1, 32'd3, 32'd4);
    finish_op("both", 32'd12, 1'b0);

    start_op(1'b1, 1'b0, 32'd5, 32'd6);
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_exc", {31'd0, exception}, 32'd0);
    chk("arst_rdy", {31'd0, resultRDY}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (resultRDY) pulses++;
    end
    chk("arst_no_rdy", 32'(pulses), 32'd0);

    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    finish_op("div_m7_m2", 32'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, beside the bitwise/arithmetic ALU.
- Takes the same operandA/operandB that feed the ALU.
- Its result joins the ALU result in the execute-stage result mux, ahead of the X/M latch.
- Multicycle: the pipeline stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; the counter width is fixed at 6 bits.

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- operandA  input  32  multiplicand / dividend, two's complement
- operandB  input  32  multiplier / divisor, two's complement
- ctrl_MULT  input  1  one-cycle start pulse for multiply
- ctrl_DIV  input  1  one-cycle start pulse for divide
- result  output  32  low 32 bits of product, or quotient
- exception  output  1  overflow or divide-by-zero flag, qualified by resultRDY
- resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, result=0, exception=0, resultRDY=0, busy=0. Reset mid-operation aborts it; no resultRDY is produced.
- States and transitions:
  - IDLE -> MUL on ctrl_MULT.
  - IDLE -> DIV on ctrl_DIV.
  - MUL/DIV -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally, unless a start is seen that cycle.
- Start: at the edge where ctrl_MULT or ctrl_DIV is sampled high (E0), latch operandA, operandB and the op.
  - Record sign flags; load magnitudes.
  - Clear counter; busy=1 from E0.
- Start priority:
  - ctrl_MULT and ctrl_DIV both high: MULT wins.
  - A start in any state, including mid-operation or DONE, aborts the current op and restarts with the new operands. No resultRDY is issued for the aborted op.
- MUL: radix-2 shift-add on magnitudes, one bit per cycle, edges E1..E32. 64-bit product accumulator.
- DIV: restoring division on magnitudes, one quotient bit per cycle, edges E1..E32.
- Completion at E33:
  - resultRDY=1 for exactly one cycle (E33..E34); busy=0 from E33.
  - result and exception update at E33 and hold until the next start's completion or reset. A start clears neither.
  - Fixed latency for every op, including divide-by-zero: 33 cycles from start edge to resultRDY.
- Sign correction (at completion):
  - product negated if signA^signB.
  - quotient negated if signA^signB; truncation toward zero; remainder discarded.
- Multiply exception: signed 64-bit product does not fit in 32 bits, i.e. bits 63..31 not all equal. result = low 32 bits regardless.
- Divide exceptions:
  - operandB==0: exception=1, result=0.
  - operandA==0x80000000 and operandB==0xFFFFFFFF: exception=1, result=0x80000000.
- Operands are ignored after E0; changes during the op have no effect.

Decomposition:
- Shared package:
  - WIDTH=32, ITER=32.
  - State encoding IDLE/MUL/DIV/DONE (2 bits).
  - INT_MIN=0x80000000.
- Sub-module div_step (combinational):
  - Inputs: partial remainder, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Instantiated once, used by the DIV iteration.
- Multiply add-shift stays inline.

Test Plan:
- ctrl_MULT with A=7, B=-6 (0xFFFFFFFA) -> at E33 resultRDY=1 for one cycle, result=0xFFFFFFD6 (-42), exception=0, busy low from E33.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Then A=0xFFFFFFFF, B=0xFFFFFFFF -> result=1, exception=0.
- ctrl_DIV with A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. Then A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_DIV with A=5, B=0 -> at E33 result=0, exception=1, resultRDY single pulse.
- ctrl_MULT A=3, B=4; at E10 pulse ctrl_DIV A=100, B=7 -> no resultRDY near E33 of the first op; resultRDY at E10+33 with result=14. Both ctrls high together with A=3, B=4 -> multiply, result=12.
- Start ctrl_MULT, assert reset at E15 between edges -> outputs 0 immediately (async). After release, no resultRDY appears; a new start completes normally 33 cycles later.
